// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: EX-stage branch/jump resolution, flush window sequencing and 2-bit BHT prediction
module branch_redirect_ctrl #(
    parameter int BHT_IDX_W    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_is_branch_i,
    output logic        predict_taken_o,
    input  logic        ex_valid_i,
    input  logic [1:0]  ex_npctype_i,
    input  logic        ex_zero_i,
    input  logic        ex_pred_taken_i,
    input  logic [31:0] ex_pc_i,
    output logic [1:0]  next_type_o,
    output logic        flush_ifid_o,
    output logic        flush_idex_o,
    output logic        redirect_busy_o,
    output logic [15:0] mispredict_cnt_o
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam int N  = 1 << BHT_IDX_W;
    localparam logic [CW-1:0] FC1 = CW'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [1:0]           bht [N];
    logic [BHT_IDX_W-1:0] if_idx, ex_idx;
    logic                 resolve, is_br, mis, jmp, redirect, enter_flush, unused_pc;

    assign if_idx    = if_pc_i[BHT_IDX_W+1:2];
    assign ex_idx    = ex_pc_i[BHT_IDX_W+1:2];
    assign unused_pc = ^{if_pc_i[31:BHT_IDX_W+2], if_pc_i[1:0], ex_pc_i[31:BHT_IDX_W+2], ex_pc_i[1:0]};

    // Lookup sees the registered entry, so a same-cycle update is not forwarded
    assign predict_taken_o = if_is_branch_i & bht[if_idx][1];

    // Gating with rstn keeps every output low while reset is held
    always_comb begin
        resolve         = rstn && state == IDLE && !stall_i && ex_valid_i;
        is_br           = ex_npctype_i == 2'b01;
        mis             = resolve && is_br && (ex_zero_i != ex_pred_taken_i);
        jmp             = resolve && ex_npctype_i == 2'b10;
        redirect        = mis || jmp;
        enter_flush     = redirect && FLUSH_CYCLES > 1;
        next_type_o     = mis ? {ex_zero_i, 1'b1} : jmp ? 2'b10 : 2'b00;
        flush_idex_o    = redirect;
        flush_ifid_o    = redirect || (rstn && state == FLUSH && !stall_i);
        redirect_busy_o = rstn && state == FLUSH;
        state_nxt       = stall_i ? state :
                          state == FLUSH ? (cnt == CW'(1) ? IDLE : FLUSH) :
                          enter_flush ? FLUSH : IDLE;
        cnt_nxt         = stall_i ? cnt :
                          state == FLUSH ? cnt - CW'(1) :
                          enter_flush ? FC1 : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            cnt              <= '0;
            mispredict_cnt_o <= '0;
            for (int i = 0; i < N; i++) bht[i] <= 2'b01;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (mis && !(&mispredict_cnt_o)) mispredict_cnt_o <= mispredict_cnt_o + 16'd1;
            if (resolve && is_br)
                bht[ex_idx] <= ex_zero_i ? (bht[ex_idx] == 2'b11 ? 2'b11 : bht[ex_idx] + 2'b01)
                                         : (bht[ex_idx] == 2'b00 ? 2'b00 : bht[ex_idx] - 2'b01);
        end
    end
endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
Control-hazard sequencer for the 5-stage pipelined CPU.
- Resolves branch/jump outcomes in EX and drives the next-PC source select and the IF/ID, ID/EX flushes.
- Holds the post-redirect flush window.
- Owns a small 2-bit saturating branch history table (BHT) that supplies IF-stage predictions and counts mispredicts.
- Sits between the hazard unit, the NPC mux and the pipeline registers.

Parameters:
BHT_IDX_W, 4, BHT index width (2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2])
FLUSH_CYCLES, 2, cycles flush_ifid_o stays high per redirect (>=1)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
stall_i  in  1  hazard-unit stall; freezes this block
if_pc_i  in  32  fetch-stage PC for prediction lookup
if_is_branch_i  in  1  predecode: IF instruction is a conditional branch
predict_taken_o  out  1  BHT prediction for if_pc_i
ex_valid_i  in  1  EX holds a live (non-bubble) instruction
ex_npctype_i  in  2  EX NPC type: 00 PC+4, 01 Branch, 10 Jump, 11 reserved
ex_zero_i  in  1  ALU zero; branch actually taken when 1
ex_pred_taken_i  in  1  prediction carried down with the EX instruction
ex_pc_i  in  32  PC of EX instruction (BHT update index)
next_type_o  out  2  NPC select: 00 PC+4, 01 EX PC+4 (fall-through recovery), 10 jump target, 11 EX branch target
flush_ifid_o  out  1  squash IF/ID
flush_idex_o  out  1  squash ID/EX
redirect_busy_o  out  1  flush window active
mispredict_cnt_o  out  16  saturating branch-mispredict count

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, flush counter=0, all BHT entries=2'b01 (weakly not-taken), mispredict_cnt_o=0.
  - Every output is 0 while in reset.
- predict_taken_o:
  - Combinational: if_is_branch_i & BHT[if_pc_i idx][1].
  - Reads the pre-update value when the same index is written that cycle.
- FSM states: IDLE and FLUSH.
- Resolution occurs only when state=IDLE, stall_i=0 and ex_valid_i=1:
  - Branch, ex_zero_i != ex_pred_taken_i (mispredict):
    - next_type_o=11 if ex_zero_i=1, else 01.
    - flush_ifid_o=1 and flush_idex_o=1, combinational in the same cycle.
    - mispredict_cnt_o increments at the clock edge and saturates at 16'hFFFF.
  - Branch, correct prediction: next_type_o=00, no flush.
  - Jump: next_type_o=10, flush_ifid_o=1 and flush_idex_o=1, no count.
  - PC+4 or reserved: next_type_o=00, no action.
  - Any redirect (mispredict or jump) with FLUSH_CYCLES>1 → FLUSH with counter=FLUSH_CYCLES-1. With FLUSH_CYCLES=1 the state stays IDLE.
- BHT update:
  - Occurs on every resolved Branch (predicted correctly or not), at the clock edge.
  - Taken → increment, saturating at 11. Not taken → decrement, saturating at 00.
  - Index is ex_pc_i[BHT_IDX_W+1:2].
- FLUSH state:
  - flush_ifid_o=1, flush_idex_o=0, next_type_o=00, redirect_busy_o=1.
  - ex_valid_i is ignored (the instruction is squashed): no BHT update, no count.
  - Counter decrements each unstalled cycle; at 1→0 the FSM returns to IDLE on that edge.
- stall_i=1:
  - State, counter, BHT and mispredict count hold.
  - next_type_o=00, flush outputs 0 (no resolution).
  - redirect_busy_o reflects the held state.
- Reset asserted mid-FLUSH aborts the window immediately. After rstn rises, the block is in IDLE with no flush pending.
- Redirect and stall in the same cycle: stall wins. Resolution is deferred to the first unstalled cycle, when the EX instruction is still presented.

Test Plan:
- Reset, then idle with ex_valid_i=0 → all outputs 0; predict_taken_o=0 for any branch PC (entries 01).
- Branch at ex_pc_i=0x40, pred=0, zero=1 → next_type_o=11, both flushes high for 1 cycle; flush_ifid_o high 1 more cycle; redirect_busy_o high 1 cycle; mispredict_cnt_o=1; BHT[0] becomes 10, so predict_taken_o=1 for if_pc_i=0x40 with if_is_branch_i=1.
- Jump in EX → next_type_o=10, flushes per FLUSH_CYCLES=2, mispredict_cnt_o unchanged; a Branch mispredict presented during FLUSH is ignored (no count, no BHT change).
- Same branch taken 4 times → counter saturates at 11; then two not-taken → 01, with predict_taken_o falling to 0 after the second.
- stall_i=1 coincident with a mispredict for 3 cycles → outputs 00/0; on the cycle stall_i drops → redirect fires exactly once, count +1.
- rstn pulsed low during FLUSH → flushes drop asynchronously; BHT back to 01; mispredict_cnt_o=0.
